msu_stream_ctrl: RTL

Parametrised sector-streaming controller for MSU-1 PCM tracks. It requests sectors from the HPS SD interface and captures the 8-byte header (loop index). It gates every incoming word into the audio FIFO, dropping header words, pre-loop-point words and words past end-of-file. Handles play, pause, stop, repeat/loop, FIFO back-pressure and remount. Sits between the HPS sd_* channel and the audio FIFO.

---
 rtl/msu_pkg.sv | 37 +++
 rtl/msu_if.sv | 25 ++
 rtl/msu_word_gate.sv | 59 +++++
 rtl/msu_stream_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/msu_pkg.sv
// Shared types and helpers for the MSU-1 PCM sector-streaming controller:
// controller states, header word offsets and track-geometry arithmetic.
package msu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    XFER,
    CHECK,
    PAUSED
  } msu_state_e;

  localparam int HDR_LOOP_LO = 2;
  localparam int HDR_LOOP_HI = 3;

  function automatic logic [32:0] calc_end_word(input logic [31:0] img_size);
    return {2'b00, img_size[31:1]};
  endfunction

  function automatic logic [31:0] calc_last_lba(input logic [31:0] img_size,
                                                input int          sect_log2);
    return (img_size - 32'd1) >> (sect_log2 + 1);
  endfunction

  // Loop point in file words; saturates instead of wrapping, and a loop point
  // at or past end-of-file falls back to the first audio word.
  function automatic logic [32:0] calc_loop_word(input logic [31:0] loop_index,
                                                 input logic [32:0] end_word,
                                                 input int          hdr_words);
    logic [33:0] raw;
    logic [32:0] sat;
    raw = {1'b0, loop_index, 1'b0} + 34'(hdr_words);
    sat = raw[33] ? '1 : raw[32:0];
    return (sat >= end_word) ? 33'(hdr_words) : sat;
  endfunction

endpackage

// File: rtl/msu_if.sv
// HPS sd_* sector channel plus audio FIFO write port of the MSU-1 streamer.
// master = streaming controller, slave = HPS / FIFO side.
interface msu_if #(
  parameter int LBA_W  = 21,
  parameter int FIFO_W = 12
);
  logic [LBA_W-1:0]  sd_lba;
  logic              sd_rd;
  logic              sd_ack;
  logic              sd_buff_wr;
  logic [15:0]       sd_buff_dout;
  logic              fifo_wr;
  logic [15:0]       fifo_data;
  logic [FIFO_W-1:0] fifo_usedw;

  modport master (
    output sd_lba, sd_rd, fifo_wr, fifo_data,
    input  sd_ack, sd_buff_wr, sd_buff_dout, fifo_usedw
  );

  modport slave (
    input  sd_lba, sd_rd, fifo_wr, fifo_data,
    output sd_ack, sd_buff_wr, sd_buff_dout, fifo_usedw
  );
endinterface

// File: rtl/msu_word_gate.sv
// Per-word datapath: sector word counter, file-word window gate into the
// audio FIFO and loop-index capture from the track header.
module msu_word_gate
  import msu_pkg::*;
#(
  parameter int LBA_W     = 21,
  parameter int SECT_LOG2 = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             clr,
  input  logic             acc,
  input  logic [LBA_W-1:0] lba,
  input  logic [15:0]      din,
  input  logic [32:0]      start_word,
  input  logic [32:0]      end_word,
  output logic             wr_p1,
  output logic [15:0]      data_p1,
  output logic [31:0]      loop_index
);

  localparam logic [SECT_LOG2:0] WC_LO = (SECT_LOG2+1)'(HDR_LOOP_LO);
  localparam logic [SECT_LOG2:0] WC_HI = (SECT_LOG2+1)'(HDR_LOOP_HI);

  logic [SECT_LOG2:0]         wc;
  logic [LBA_W+SECT_LOG2-1:0] fw;
  logic [32:0]                fw_x;
  logic                       pass;
  logic                       hdr_sect;

  assign fw       = {lba, wc[SECT_LOG2-1:0]};
  assign fw_x     = 33'(fw);
  assign pass     = acc && (fw_x >= start_word) && (fw_x < end_word);
  assign hdr_sect = acc && (lba == '0);

  // p0 -> p1: accepted word registered towards the FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wc         <= '0;
      wr_p1      <= 1'b0;
      data_p1    <= '0;
      loop_index <= '0;
    end else if (abort) begin
      wc         <= '0;
      wr_p1      <= 1'b0;
      data_p1    <= '0;
      loop_index <= '0;
    end else begin
      wr_p1 <= pass;
      if (acc) data_p1 <= din;
      if (clr)      wc <= '0;
      else if (acc) wc <= wc + 1'b1;
      if (hdr_sect && wc == WC_LO) loop_index[15:0]  <= din;
      if (hdr_sect && wc == WC_HI) loop_index[31:16] <= din;
    end
  end

endmodule

// File: rtl/msu_stream_ctrl.sv
// MSU-1 PCM sector-streaming controller: sector requests, play/pause/stop/loop.
// Build option MSU_RESUME_EN adds play_resume and restart from the saved sector.
module msu_stream_ctrl
  import msu_pkg::*;
#(
  parameter int LBA_W     = 21,
  parameter int SECT_LOG2 = 8,
  parameter int FIFO_W    = 12,
  parameter int FIFO_HIGH = 1792,
  parameter int HDR_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] img_size,
  input  logic        img_mounted,
  input  logic        trig_play,
  input  logic        trig_pause,
  input  logic        trig_stop,
  input  logic        repeat_en,
`ifdef MSU_RESUME_EN
  input  logic        play_resume,
`endif
  msu_if.master       bus,
  output logic        playing,
  output logic [31:0] loop_index,
  output logic        track_end
);

  localparam logic [32:0]       HDR_W33   = 33'(HDR_WORDS);
  localparam logic [FIFO_W-1:0] HIGH_MARK = FIFO_W'(FIFO_HIGH);
  localparam logic [31:0]       MIN_SIZE  = 32'(2 * HDR_WORDS);

  msu_state_e       state, state_n;
  logic [LBA_W-1:0] lba, lba_n, last_lba, play_lba;
  logic [32:0]      start_word, start_n, end_word, loop_word, play_start;
  logic             ack_q, ack_rise, ack_fall;
  logic             pause_pend, pause_n, stop_pend, stop_n, track_end_n;
  logic             play_go, acc, xfer_start;

  assign ack_rise   = bus.sd_ack && !ack_q;
  assign ack_fall   = !bus.sd_ack && ack_q;
  assign end_word   = calc_end_word(img_size);
  assign last_lba   = LBA_W'(calc_last_lba(img_size, SECT_LOG2));
  assign loop_word  = calc_loop_word(loop_index, end_word, HDR_WORDS);
  assign play_go    = trig_play && !trig_pause && !trig_stop;
  assign acc        = (state == XFER) && bus.sd_ack && bus.sd_buff_wr;
  assign xfer_start = (state == REQ) && ack_rise;

  assign bus.sd_lba = lba;
  // A request stays masked while an aborted transfer still holds sd_ack.
  assign bus.sd_rd  = (state == REQ) && !ack_q;
  assign playing    = (state == REQ) || (state == XFER) || (state == CHECK);

`ifdef MSU_RESUME_EN
  logic [LBA_W-1:0] resume_lba;
  logic [32:0]      resume_start;

  always_comb begin
    resume_start = 33'(resume_lba) << SECT_LOG2;
    if (resume_start < HDR_W33) resume_start = HDR_W33;
    play_lba   = play_resume ? resume_lba : '0;
    play_start = play_resume ? resume_start : HDR_W33;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      resume_lba <= '0;
    else if (img_mounted)
      resume_lba <= '0;
    else if ((state != PAUSED && state_n == PAUSED) ||
             (state != IDLE && state_n == IDLE && !track_end_n))
      resume_lba <= lba;
  end
`else
  assign play_lba   = '0;
  assign play_start = HDR_W33;
`endif

  always_comb begin
    state_n     = state;
    lba_n       = lba;
    start_n     = start_word;
    pause_n     = pause_pend;
    stop_n      = stop_pend;
    track_end_n = 1'b0;
    case (state)
      IDLE: begin
        pause_n = 1'b0;
        stop_n  = 1'b0;
        if (play_go) begin
          if (img_size <= MIN_SIZE) begin
            track_end_n = 1'b1;
          end else begin
            lba_n   = play_lba;
            start_n = play_start;
            state_n = REQ;
          end
        end
      end
      REQ: begin
        if (trig_stop)  stop_n  = 1'b1;
        if (trig_pause) pause_n = 1'b1;
        if (ack_rise)       state_n = XFER;
        else if (trig_stop) state_n = IDLE;
      end
      XFER: begin
        // Stop and pause only take effect once the HPS finishes the sector.
        if (trig_stop)  stop_n  = 1'b1;
        if (trig_pause) pause_n = 1'b1;
        if (ack_fall) begin
          if (stop_n)       state_n = IDLE;
          else if (pause_n) state_n = PAUSED;
          else              state_n = CHECK;
        end
      end
      CHECK: begin
        if (trig_stop) begin
          state_n = IDLE;
        end else if (trig_pause) begin
          state_n = PAUSED;
        end else if (lba < last_lba) begin
          if (bus.fifo_usedw < HIGH_MARK) begin
            lba_n   = lba + 1'b1;
            state_n = REQ;
          end
        end else if (repeat_en) begin
          lba_n   = LBA_W'(loop_word >> SECT_LOG2);
          start_n = loop_word;
          state_n = REQ;
        end else begin
          track_end_n = 1'b1;
          lba_n       = '0;
          state_n     = IDLE;
        end
      end
      PAUSED: begin
        pause_n = 1'b0;
        stop_n  = 1'b0;
        if (trig_stop)    state_n = IDLE;
        else if (play_go) state_n = CHECK;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lba        <= '0;
      start_word <= '0;
      ack_q      <= 1'b0;
      pause_pend <= 1'b0;
      stop_pend  <= 1'b0;
      track_end  <= 1'b0;
    end else if (img_mounted) begin
      state      <= IDLE;
      lba        <= '0;
      start_word <= '0;
      ack_q      <= 1'b0;
      pause_pend <= 1'b0;
      stop_pend  <= 1'b0;
      track_end  <= 1'b0;
    end else begin
      state      <= state_n;
      lba        <= lba_n;
      start_word <= start_n;
      ack_q      <= bus.sd_ack;
      pause_pend <= pause_n;
      stop_pend  <= stop_n;
      track_end  <= track_end_n;
    end
  end

  msu_word_gate #(
    .LBA_W     (LBA_W),
    .SECT_LOG2 (SECT_LOG2)
  ) u_gate (
    .clk        (clk),
    .reset      (reset),
    .abort      (img_mounted),
    .clr        (xfer_start),
    .acc        (acc),
    .lba        (lba),
    .din        (bus.sd_buff_dout),
    .start_word (start_word),
    .end_word   (end_word),
    .wr_p1      (bus.fifo_wr),
    .data_p1    (bus.fifo_data),
    .loop_index (loop_index)
  );

endmodule
